// File: rtl/spram_pkg.sv
// Shared types for the two-requester single-port RAM arbiter.
package spram_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  typedef struct packed {
    logic vld;
    logic id;
    logic wr;
  } rsp_tag_t;
endpackage

// File: rtl/spram_arbiter_if.sv
// Requester-side command/response bundle; the master drives commands, the slave (arbiter) answers.
interface spram_arbiter_if
  import spram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [1:0]          req_valid;
  logic [1:0]          req_wr;
  logic [1:0]          req_lock;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_ready;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_wr, req_lock, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_lock, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/spram_arbiter_rr_arb2.sv
// Combinational 2-way round-robin grant; 'hold' restricts the grant to the lock owner.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       rr,
  input  logic       hold,
  input  logic       owner,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    if (hold) begin
      grant[owner] = valid[owner];
    end else if (&valid) begin
      grant[rr] = 1'b1;
    end else begin
      grant = valid;
    end
  end
endmodule

// File: rtl/spram_arbiter.sv
// Round-robin arbiter/sequencer for a single-port RAM: 2-cycle accept-to-response, one access per cycle.
// Requesters are back-pressured only by arbitration; responses cannot be stalled.
module spram_arbiter
  import spram_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  spram_arbiter_if.slave    bus,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_select,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);
  localparam int               CNT_W   = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

  lock_state_t       state, state_nxt;
  logic              owner, owner_nxt;
  logic              rr, rr_nxt;
  logic [CNT_W-1:0]  lock_cnt, cnt_nxt;
  logic              hold;
  logic [1:0]        grant;
  logic              gnt_any, gnt_id, gnt_wr, gnt_lock;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;
  rsp_tag_t          s1, s2;

  assign hold = (state == LOCKED) && bus.req_valid[owner] && bus.req_lock[owner]
                && (lock_cnt < CNT_MAX);

  rr_arb2 u_arb (
    .valid (bus.req_valid),
    .rr    (rr),
    .hold  (hold),
    .owner (owner),
    .grant (grant)
  );

  assign bus.req_ready = rst_n ? grant : 2'b00;
  assign gnt_any   = |bus.req_ready;
  assign gnt_id    = bus.req_ready[1];
  assign gnt_wr    = bus.req_wr[gnt_id];
  assign gnt_lock  = bus.req_lock[gnt_id];
  assign gnt_addr  = gnt_id ? bus.req_addr[2*ADDR_W-1:ADDR_W]  : bus.req_addr[ADDR_W-1:0];
  assign gnt_wdata = gnt_id ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      rr       <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr       <= rr_nxt;
      lock_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr;
    cnt_nxt   = lock_cnt;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          rr_nxt = ~gnt_id;
          if (gnt_lock) begin
            state_nxt = LOCKED;
            owner_nxt = gnt_id;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      LOCKED: begin
        if (hold) begin
          // Lock extensions leave rr untouched so the other side wins on release.
          if (gnt_any && lock_cnt != CNT_MAX) cnt_nxt = lock_cnt + CNT_W'(1);
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          rr_nxt    = gnt_any ? ~gnt_id : ~owner;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wr     <= 1'b0;
      ram_select <= '0;
      ram_in     <= '0;
      s1         <= '0;
      s2         <= '0;
    end else begin
      ram_wr <= gnt_any & gnt_wr;
      if (gnt_any) begin
        ram_select <= gnt_addr;
        ram_in     <= gnt_wdata;
      end
      s1 <= '{vld: gnt_any, id: gnt_id, wr: gnt_any & gnt_wr};
      s2 <= s1;
    end
  end

  // RAM read data lands one edge after the command, aligned with s2.
  assign bus.rsp_valid = s2.vld ? (s2.id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_rdata = (s2.vld && !s2.wr) ? ram_out : '0;
endmodule
